command_control_hub_gen2: RTL and testbench
===========================================

// Module: command_control_hub_gen2
// PURPOSE
//  Parametrised successor to the PicoBlaze command & control hub: decodes port_id/strobes
//  into NUM_REGS LogCap register pairs, command strobe, UART FIFOs, LEDs, switches, buttons.
//  Adds a maskable, sticky, 4-source interrupt controller with an ack/clear state machine,
//  a programmable tick period and TX-overflow detection. Sits between the KCPSM core and LogCap/UART.
// PARAMETERS
//  NUM_REGS     8            LogCap register pairs; power of 2, 2..16; occupy ports 0x00..NUM_REGS-1
//  TICK_PERIOD  100_000_000  clk cycles per timer tick (1 s at 100 MHz); >= 2
// PORTS
//  clk                     in   1           system clock, all logic on rising edge
//  reset                   in   1           asynchronous, active-low reset
//  led                     out  16          LED drive
//  button                  in   8           buttons (pre-debounced)
//  switch                  in   16          slide switches
//  interrupt               out  1           to KCPSM interrupt input
//  interrupt_ack           in   1           from KCPSM, 1-cycle pulse
//  port_id                 in   8           I/O address
//  port_out                in   8           write data
//  port_in                 out  8           read data, registered
//  write_strobe            in   1           write qualifier
//  read_strobe             in   1           read qualifier
//  data_rx                 in   8           UART RX FIFO head
//  urx_buffer_full/half_full/data_present in 1 each  RX FIFO flags
//  urx_buffer_read         out  1           RX FIFO pop, 1-cycle pulse
//  data_tx                 out  8           = port_out
//  utx_buffer_full/half_full/data_present in 1 each  TX FIFO flags
//  utx_buffer_write        out  1           TX FIFO push, combinational
//  regIn                   in   8*NUM_REGS  LogCap readback, reg k = [8k+7:8k]
//  regOut                  out  8*NUM_REGS  LogCap config, reg k = [8k+7:8k]
//  command                 out  8           LogCap command byte
//  command_strobe          out  1           1-cycle pulse
//  status                  in   8           LogCap status
// BEHAVIOUR
//  Reset (reset=0, async): led, regOut, command, port_in, irq_pending = 0; irq_mask = 0x01;
//   outputs command_strobe, urx_buffer_read, interrupt = 0; tx_ovf = 0; timer = 0; FSM = IDLE.
//  Writes (write_strobe=1): 0x00..NUM_REGS-1 -> regOut[k]; 0x20 command<=port_out, command_strobe=1
//   next cycle only; 0x21 UART TX; 0x22 led[7:0]; 0x23 led[15:8]; 0x24 irq_mask[3:0];
//   0x25 irq_pending &= ~port_out[3:0] (W1C). Other addresses ignored (no state change).
//  Reads: port_in <= mux(port_id) every cycle, valid 1 cycle after port_id; regs 0x00..NUM_REGS-1
//   regIn[k]; 0x20 status; 0x21 data_rx; 0x22 {tx_ovf,1'b0,urx_full,urx_half,urx_dp,utx_full,
//   utx_half,utx_dp}; 0x23 switch[7:0]; 0x24 switch[15:8]; 0x25 button; 0x26 {4'b0,irq_pending};
//   0x27 {4'b0,irq_mask}; unmapped -> 0x00 (never X).
//  urx_buffer_read: 1-cycle pulse the cycle after read_strobe && port_id==0x21.
//  Read of 0x22 (read_strobe) clears tx_ovf the following cycle; a new overflow that cycle wins.
//  utx_buffer_write = write_strobe && port_id==0x21 && !utx_buffer_full; write when full dropped,
//   tx_ovf <= 1 (sticky).
//  Timer: counts 0..TICK_PERIOD-1, wraps; tick is 1 cycle at terminal count; free-running.
//  IRQ sources (set pending bit, sticky): b0 tick; b1 rising edge of urx_buffer_data_present;
//   b2 status != previous-cycle status; b3 any button rising edge. Set beats W1C same cycle.
//  IRQ FSM: IDLE: interrupt=0; if |(pending&mask) -> ASSERT.
//   ASSERT: interrupt=1, held until interrupt_ack=1 -> SERVICE (interrupt=0 next cycle).
//   SERVICE: interrupt=0; when (pending&mask)==0 -> IDLE. New sources only re-fire via IDLE.
//   interrupt_ack in IDLE/SERVICE ignored. interrupt is a registered FSM output.
//  Reset mid-operation: all above reset values apply immediately; pending events lost.
// TESTING
//  1 Write 0xA5 to 0x03, read 0x03 -> regOut[31:24]=0xA5; port_in = regIn[31:24] 1 cycle later.
//  2 Write 0x3C to 0x20 -> command=0x3C, command_strobe high exactly 1 cycle.
//  3 TICK_PERIOD=10, mask=0x01 -> interrupt rises after tick; hold until ack; clear via 0x25
//    write 0x01 -> IDLE; next tick 10 cycles after previous re-asserts.
//  4 utx_buffer_full=1, write 0x21 -> utx_buffer_write=0, 0x22 reads bit7=1; second read bit7=0.
//  5 Tick and W1C of b0 same cycle -> pending[0] stays 1; mask=0 -> interrupt stays 0.
//  6 Assert reset low mid-ASSERT -> interrupt, command_strobe, urx_buffer_read 0 asynchronously.

Source files
------------

// File: rtl/command_control_hub_gen2_if.sv
// command_control_hub_gen2_if: KCPSM I/O port bus plus interrupt request/acknowledge handshake
interface command_control_hub_gen2_if;
  logic [7:0] port_id;
  logic [7:0] port_out;
  logic [7:0] port_in;
  logic       write_strobe;
  logic       read_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  modport master (
    output port_id, port_out, write_strobe, read_strobe, interrupt_ack,
    input  port_in, interrupt
  );
  modport slave (
    input  port_id, port_out, write_strobe, read_strobe, interrupt_ack,
    output port_in, interrupt
  );
endinterface

// File: rtl/command_control_hub_gen2.sv
// command_control_hub_gen2: KCPSM port decoder for LogCap registers, UART FIFOs, GPIO and a sticky maskable interrupt controller
module command_control_hub_gen2 #(
  parameter int NUM_REGS    = 8,
  parameter int TICK_PERIOD = 100_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  command_control_hub_gen2_if.slave bus,
  output logic [15:0]               led,
  input  logic [7:0]                button,
  input  logic [15:0]               switch,
  input  logic [7:0]                data_rx,
  input  logic                      urx_buffer_full,
  input  logic                      urx_buffer_half_full,
  input  logic                      urx_buffer_data_present,
  output logic                      urx_buffer_read,
  output logic [7:0]                data_tx,
  input  logic                      utx_buffer_full,
  input  logic                      utx_buffer_half_full,
  input  logic                      utx_buffer_data_present,
  output logic                      utx_buffer_write,
  input  logic [8*NUM_REGS-1:0]     regIn,
  output logic [8*NUM_REGS-1:0]     regOut,
  output logic [7:0]                command,
  output logic                      command_strobe,
  input  logic [7:0]                status
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int TW = $clog2(TICK_PERIOD);
  localparam logic [7:0] NREG = 8'(NUM_REGS);
  localparam logic [TW-1:0] TLAST = TW'(TICK_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} irq_state_e;
  logic [7:0] reg_q [NUM_REGS];
  logic [7:0] reg_d [NUM_REGS];
  logic [7:0] reg_in_a [NUM_REGS];
  logic [15:0] led_q, led_d;
  logic [7:0] cmd_q, cmd_d, port_in_q, port_in_d;
  logic [7:0] status_q, status_d, button_q, button_d;
  logic cmd_stb_q, cmd_stb_d, urx_rd_q, urx_rd_d, tx_ovf_q, tx_ovf_d;
  logic urx_dp_q, urx_dp_d, intr_q, intr_d;
  logic [3:0] mask_q, mask_d, pend_q, pend_d, irq_set;
  logic [TW-1:0] timer_q, timer_d;
  irq_state_e state_q, state_d;
  logic wr_reg, wr_cmd, wr_tx, wr_led_lo, wr_led_hi, wr_mask, wr_w1c, rd_rx, rd_flags, tick;
  assign wr_reg    = bus.write_strobe && (bus.port_id < NREG);
  assign wr_cmd    = bus.write_strobe && bus.port_id == 8'h20;
  assign wr_tx     = bus.write_strobe && bus.port_id == 8'h21;
  assign wr_led_lo = bus.write_strobe && bus.port_id == 8'h22;
  assign wr_led_hi = bus.write_strobe && bus.port_id == 8'h23;
  assign wr_mask   = bus.write_strobe && bus.port_id == 8'h24;
  assign wr_w1c    = bus.write_strobe && bus.port_id == 8'h25;
  assign rd_rx     = bus.read_strobe && bus.port_id == 8'h21;
  assign rd_flags  = bus.read_strobe && bus.port_id == 8'h22;
  assign tick      = timer_q == TLAST;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign regOut[8*i +: 8] = reg_q[i];
    assign reg_in_a[i]      = regIn[8*i +: 8];
  end
  always_comb begin
    port_in_d = 8'h00;
    if (bus.port_id < NREG) port_in_d = reg_in_a[bus.port_id[IW-1:0]];
    else
      case (bus.port_id)
        8'h20:   port_in_d = status;
        8'h21:   port_in_d = data_rx;
        8'h22:   port_in_d = {tx_ovf_q, 1'b0, urx_buffer_full, urx_buffer_half_full, urx_buffer_data_present,
                              utx_buffer_full, utx_buffer_half_full, utx_buffer_data_present};
        8'h23:   port_in_d = switch[7:0];
        8'h24:   port_in_d = switch[15:8];
        8'h25:   port_in_d = button;
        8'h26:   port_in_d = {4'h0, pend_q};
        8'h27:   port_in_d = {4'h0, mask_q};
        default: port_in_d = 8'h00;
      endcase
  end
  always_comb begin
    reg_d = reg_q;
    if (wr_reg) reg_d[bus.port_id[IW-1:0]] = bus.port_out;
    led_d     = {wr_led_hi ? bus.port_out : led_q[15:8], wr_led_lo ? bus.port_out : led_q[7:0]};
    cmd_d     = wr_cmd ? bus.port_out : cmd_q;
    cmd_stb_d = wr_cmd;
    urx_rd_d  = rd_rx;
    // An overflow in the same cycle as the flag read must not be lost
    tx_ovf_d  = (wr_tx && utx_buffer_full) ? 1'b1 : (rd_flags ? 1'b0 : tx_ovf_q);
    timer_d   = tick ? '0 : timer_q + TW'(1);
    status_d  = status;
    button_d  = button;
    urx_dp_d  = urx_buffer_data_present;
    irq_set   = {|(button & ~button_q), status != status_q, urx_buffer_data_present & ~urx_dp_q, tick};
    pend_d    = (pend_q & ~(wr_w1c ? bus.port_out[3:0] : 4'h0)) | irq_set;
    mask_d    = wr_mask ? bus.port_out[3:0] : mask_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|(pend_q & mask_q)) state_d = ASSERT;
      ASSERT:  if (bus.interrupt_ack) state_d = SERVICE;
      SERVICE: if (~|(pend_q & mask_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    intr_d = state_d == ASSERT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reg_q     <= '{default: 8'h00};
      led_q     <= '0;
      cmd_q     <= '0;
      cmd_stb_q <= 1'b0;
      port_in_q <= '0;
      urx_rd_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      timer_q   <= '0;
      status_q  <= '0;
      button_q  <= '0;
      urx_dp_q  <= 1'b0;
      pend_q    <= '0;
      mask_q    <= 4'h1;
      state_q   <= IDLE;
      intr_q    <= 1'b0;
    end else begin
      reg_q     <= reg_d;
      led_q     <= led_d;
      cmd_q     <= cmd_d;
      cmd_stb_q <= cmd_stb_d;
      port_in_q <= port_in_d;
      urx_rd_q  <= urx_rd_d;
      tx_ovf_q  <= tx_ovf_d;
      timer_q   <= timer_d;
      status_q  <= status_d;
      button_q  <= button_d;
      urx_dp_q  <= urx_dp_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      state_q   <= state_d;
      intr_q    <= intr_d;
    end
  assign led              = led_q;
  assign command          = cmd_q;
  assign command_strobe   = cmd_stb_q;
  assign urx_buffer_read  = urx_rd_q;
  assign data_tx          = bus.port_out;
  assign utx_buffer_write = wr_tx && !utx_buffer_full;
  assign bus.port_in      = port_in_q;
  assign bus.interrupt    = intr_q;
endmodule

// File: tb/tb_command_control_hub_gen2.sv
// tb_command_control_hub_gen2: directed stimulus, outputs compared every cycle against a behavioural model of the hub
module tb_command_control_hub_gen2;
  localparam int NR = 8;
  localparam int TP = 10;
  logic clk = 1'b0, reset = 1'b1, chk_en = 1'b0;
  logic [15:0] led, switch;
  logic [7:0] button, data_rx, data_tx, command, status;
  logic urx_full, urx_half, urx_dp, urx_read, utx_full, utx_half, utx_dp, utx_write, command_strobe;
  logic [63:0] reg_in, reg_out;
  int vectors = 0, miscompares = 0;
  command_control_hub_gen2_if bus ();
  command_control_hub_gen2 #(.NUM_REGS(NR), .TICK_PERIOD(TP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .led(led), .button(button), .switch(switch),
    .data_rx(data_rx), .urx_buffer_full(urx_full), .urx_buffer_half_full(urx_half),
    .urx_buffer_data_present(urx_dp), .urx_buffer_read(urx_read), .data_tx(data_tx),
    .utx_buffer_full(utx_full), .utx_buffer_half_full(utx_half), .utx_buffer_data_present(utx_dp),
    .utx_buffer_write(utx_write), .regIn(reg_in), .regOut(reg_out), .command(command),
    .command_strobe(command_strobe), .status(status)
  );
  always #5 clk = ~clk;
  logic [15:0] m_led;
  logic [63:0] m_regout;
  logic [7:0] m_cmd, m_port_in, m_prev_status, m_prev_btn;
  logic m_cmd_stb, m_urx_rd, m_ovf, m_prev_dp, m_irq, m_busy;
  logic [3:0] m_mask, m_pend;
  int m_cnt;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] rd_val(input logic [7:0] a);
    if (a < NR) return reg_in[8*int'(a) +: 8];
    case (a)
      8'h20: return status;
      8'h21: return data_rx;
      8'h22: return {m_ovf, 1'b0, urx_full, urx_half, urx_dp, utx_full, utx_half, utx_dp};
      8'h23: return switch[7:0];
      8'h24: return switch[15:8];
      8'h25: return button;
      8'h26: return {4'h0, m_pend};
      8'h27: return {4'h0, m_mask};
      default: return 8'h00;
    endcase
  endfunction
  task automatic mdl_reset();
    m_led = '0; m_regout = '0; m_cmd = '0; m_cmd_stb = 0; m_port_in = '0; m_urx_rd = 0; m_ovf = 0;
    m_mask = 4'h1; m_pend = '0; m_cnt = 0; m_prev_dp = 0; m_prev_status = '0; m_prev_btn = '0;
    m_irq = 0; m_busy = 0;
  endtask
  task automatic mdl_step();
    logic [7:0] a = bus.port_id;
    logic [7:0] d = bus.port_out;
    logic ws = bus.write_strobe;
    logic rs = bus.read_strobe;
    logic eff = |(m_pend & m_mask);
    logic [3:0] events = {|(button & ~m_prev_btn), status != m_prev_status, urx_dp && !m_prev_dp,
                          (m_cnt % TP) == TP - 1};
    m_port_in = rd_val(a);
    m_cmd_stb = ws && a == 8'h20;
    m_urx_rd  = rs && a == 8'h21;
    if (ws && a < NR) m_regout[8*int'(a) +: 8] = d;
    if (ws && a == 8'h20) m_cmd = d;
    if (ws && a == 8'h22) m_led[7:0] = d;
    if (ws && a == 8'h23) m_led[15:8] = d;
    if (ws && a == 8'h21 && utx_full) m_ovf = 1;
    else if (rs && a == 8'h22) m_ovf = 0;
    // request raised once per episode; after ack, wait for all enabled pending bits to clear
    if (m_irq) begin
      if (bus.interrupt_ack) begin m_irq = 0; m_busy = 1; end
    end else if (m_busy) m_busy = eff;
    else m_irq = eff;
    m_pend = (m_pend & ~((ws && a == 8'h25) ? d[3:0] : 4'h0)) | events;
    if (ws && a == 8'h24) m_mask = d[3:0];
    m_prev_btn = button; m_prev_status = status; m_prev_dp = urx_dp;
    m_cnt++;
  endtask
  task automatic cyc();
    @(posedge clk);
    if (!reset) mdl_reset(); else mdl_step();
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.port_id = a; bus.port_out = d; bus.write_strobe = 1; cyc(); bus.write_strobe = 0;
  endtask
  task automatic rd(input logic [7:0] a);
    bus.port_id = a; bus.read_strobe = 1; cyc(); bus.read_strobe = 0;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      check("led", led, m_led);
      check("regOut", reg_out, m_regout);
      check("command", command, m_cmd);
      check("command_strobe", command_strobe, m_cmd_stb);
      check("port_in", bus.port_in, m_port_in);
      check("urx_buffer_read", urx_read, m_urx_rd);
      check("interrupt", bus.interrupt, m_irq);
      check("utx_buffer_write", utx_write, bus.write_strobe && bus.port_id == 8'h21 && !utx_full);
      check("data_tx", data_tx, bus.port_out);
    end
  initial begin
    bus.port_id = 0; bus.port_out = 0; bus.write_strobe = 0; bus.read_strobe = 0; bus.interrupt_ack = 0;
    button = 0; switch = 0; data_rx = 0; status = 0;
    {urx_full, urx_half, urx_dp, utx_full, utx_half, utx_dp} = '0;
    reg_in = 64'h8877_6655_4433_2211;
    #2 reset = 0; mdl_reset(); chk_en = 1;
    repeat (3) cyc();
    reset = 1;
    // tick interrupt, ack, W1C clear, re-fire; then tick colliding with W1C under mask 0
    for (int i = 0; i < 36; i++) begin
      bus.write_strobe = 0;
      bus.interrupt_ack = (i == 13 || i == 21);
      bus.port_id = (i == 1) ? 8'h27 : (i == 31) ? 8'h26 : 8'h00;
      if (i == 14 || i == 29) begin bus.port_id = 8'h25; bus.port_out = 8'h01; bus.write_strobe = 1; end
      if (i == 22) begin bus.port_id = 8'h24; bus.port_out = 8'h00; bus.write_strobe = 1; end
      cyc();
      if (i == 1) check("reset_mask", bus.port_in, 8'h01);
      if (i == 9 || i == 13 || i == 19 || i == 35) check($sformatf("t3_irq_low_%0d", i), bus.interrupt, 1'b0);
      if (i == 10 || i == 12 || i == 20) check($sformatf("t3_irq_high_%0d", i), bus.interrupt, 1'b1);
      if (i == 31) check("t5_pending", bus.port_in, 8'h01);
    end
    bus.write_strobe = 0; bus.interrupt_ack = 0;
    wr(8'h03, 8'hA5);
    check("t1_regout3", reg_out[31:24], 8'hA5);
    rd(8'h03);
    check("t1_port_in", bus.port_in, 8'h44);
    wr(8'h20, 8'h3C);
    check("t2_command", command, 8'h3C);
    check("t2_strobe_on", command_strobe, 1'b1);
    cyc();
    check("t2_strobe_off", command_strobe, 1'b0);
    urx_half = 1; utx_full = 1; utx_half = 1; utx_dp = 1;
    bus.port_id = 8'h21; bus.port_out = 8'h55; bus.write_strobe = 1;
    #1 check("t4_no_push", utx_write, 1'b0);
    cyc(); bus.write_strobe = 0;
    rd(8'h22);
    check("t4_ovf_set", bus.port_in, 8'h97);
    rd(8'h22);
    check("t4_ovf_clr", bus.port_in, 8'h17);
    utx_full = 0; bus.port_id = 8'h21; bus.write_strobe = 1;
    #1 check("t4_push", utx_write, 1'b1);
    cyc(); bus.write_strobe = 0;
    wr(8'h22, 8'h5A); wr(8'h23, 8'hC3);
    check("led_word", led, 16'hC35A);
    switch = 16'hBEEF;
    rd(8'h23); check("switch_lo", bus.port_in, 8'hEF);
    rd(8'h24); check("switch_hi", bus.port_in, 8'hBE);
    wr(8'h30, 8'hFF);
    rd(8'h55); check("unmapped", bus.port_in, 8'h00);
    wr(8'h24, 8'h0F); wr(8'h25, 8'h0F);
    urx_dp = 1; cyc(); status = 8'h42; cyc(); button = 8'h04; cyc(); cyc();
    rd(8'h26);
    data_rx = 8'h7E;
    rd(8'h21);
    check("rx_data", bus.port_in, 8'h7E);
    check("urx_read_on", urx_read, 1'b1);
    cyc();
    check("urx_read_off", urx_read, 1'b0);
    bus.interrupt_ack = 1; cyc(); bus.interrupt_ack = 0;
    wr(8'h25, 8'h0F);
    for (int n = 0; n < 40 && !bus.interrupt; n++) cyc();
    check("t6_irq_up", bus.interrupt, 1'b1);
    wr(8'h20, 8'h99);
    check("t6_strobe_before", command_strobe, 1'b1);
    #2 reset = 0; mdl_reset();
    #1 check("t6_irq_async", bus.interrupt, 1'b0);
    check("t6_strobe_async", command_strobe, 1'b0);
    check("t6_command_async", command, 8'h00);
    cyc(); cyc(); reset = 1;
    rd(8'h21);
    check("t6_urx_before", urx_read, 1'b1);
    #2 reset = 0; mdl_reset();
    #1 check("t6_urx_async", urx_read, 1'b0);
    cyc(); cyc(); reset = 1;
    repeat (5) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
